// File: rtl/uart_tx_if.sv
// Parallel byte handshake between a producer and the serial transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// Serial transmitter: start bit, DATA_BITS payload LSB-first, stop bit,
// each bit held CLKS_PER_BIT cycles. reset is asynchronous, active-low.
module uart_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    uart_tx_if.slave    bus,
    output logic        tx,
    output logic        busy
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IMAX = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [IW-1:0]        bidx, bidx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 tx_nxt, busy_nxt, bit_end;

    assign bus.tx_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
            bidx  <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            bidx  <= bidx_nxt;
            shreg <= shreg_nxt;
            tx    <= tx_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        bidx_nxt  = bidx;
        shreg_nxt = shreg;
        bit_end   = (timer == TMAX);
        if (state != IDLE)
            timer_nxt = bit_end ? '0 : timer + 1'b1;
        case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_nxt = START;
                    shreg_nxt = bus.tx_data;
                    timer_nxt = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    bidx_nxt  = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bidx == IMAX) state_nxt = STOP;
                    else              bidx_nxt  = bidx + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // tx/busy are registered, so they are decoded from the next state
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a CLKS_PER_BIT=4 instance and a
// CLKS_PER_BIT=1 instance, checked cycle by cycle against a scoreboard.
module tb_uart_tx;
    logic clk = 1'b0;
    logic reset;
    logic tx_a, busy_a, tx_b, busy_b;

    uart_tx_if #(.DATA_BITS(8)) ifa ();
    uart_tx_if #(.DATA_BITS(8)) ifb ();

    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa), .tx(tx_a), .busy(busy_a));
    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb), .tx(tx_b), .busy(busy_b));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    // scoreboard entry per cycle: {tx, busy, tx_ready}
    logic [2:0] exp_q[$];
    logic obs_tx[256];
    logic obs_busy[256];
    logic obs_rdy[256];

    task automatic push_frame(input logic [7:0] d, input int cpb);
        for (int c = 0; c < cpb; c++) exp_q.push_back(3'b010);
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < cpb; c++) exp_q.push_back({d[k], 2'b10});
        for (int c = 0; c < cpb; c++) exp_q.push_back(3'b110);
    endtask

    task automatic push_idle(input int n);
        for (int c = 0; c < n; c++) exp_q.push_back(3'b101);
    endtask

    task automatic capture(input bit sel_b, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_tx[base+i]   = sel_b ? tx_b : tx_a;
            obs_busy[base+i] = sel_b ? busy_b : busy_a;
            obs_rdy[base+i]  = sel_b ? ifb.tx_ready : ifa.tx_ready;
        end
    endtask

    task automatic start_a(input logic [7:0] d);
        @(posedge clk); #1;
        ifa.tx_valid = 1'b1;
        ifa.tx_data  = d;
        @(posedge clk); #1;
        ifa.tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'hA5;
        ifb.tx_valid = 1'b1; ifb.tx_data = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({tx_a, busy_a, ifa.tx_ready, tx_b, busy_b, ifb.tx_ready} !== 6'b101101) begin
                fails++;
                $display("FAIL reset_hold got=%b exp=101101",
                         {tx_a, busy_a, ifa.tx_ready, tx_b, busy_b, ifb.tx_ready});
            end
        end
        ifa.tx_valid = 1'b0;
        ifb.tx_valid = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if ({tx_a, busy_a, ifa.tx_ready, tx_b, busy_b, ifb.tx_ready} !== 6'b101101) begin
                fails++;
                $display("FAIL reset_release got=%b exp=101101",
                         {tx_a, busy_a, ifa.tx_ready, tx_b, busy_b, ifb.tx_ready});
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] e;
        int cnt;
        push_frame(8'hA5, 4);
        push_idle(1);
        start_a(8'hA5);
        capture(0, 0, 41);
        cnt = 0;
        for (int i = 0; i < 41; i++) begin
            e = exp_q.pop_front();
            cnt += int'(obs_busy[i]);
            tests++;
            if ({obs_tx[i], obs_busy[i], obs_rdy[i]} !== e) begin
                fails++;
                $display("FAIL single cyc=%0d got=%b exp=%b", i,
                         {obs_tx[i], obs_busy[i], obs_rdy[i]}, e);
            end
        end
        tests++;
        if (cnt !== 40) begin
            fails++;
            $display("FAIL single_busy_len got=%0d exp=40", cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        int second;
        push_frame(8'h00, 4); push_idle(1);
        push_frame(8'hFF, 4); push_idle(1);
        @(posedge clk); #1;
        ifa.tx_valid = 1'b1;
        ifa.tx_data  = 8'h00;
        @(posedge clk); #1;
        ifa.tx_data  = 8'hFF;
        capture(0, 0, 41);
        @(posedge clk); #1;
        ifa.tx_valid = 1'b0;
        capture(0, 41, 41);
        for (int i = 0; i < 82; i++) begin
            e = exp_q.pop_front();
            tests++;
            if ({obs_tx[i], obs_busy[i], obs_rdy[i]} !== e) begin
                fails++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", i,
                         {obs_tx[i], obs_busy[i], obs_rdy[i]}, e);
            end
        end
        second = -1;
        for (int i = 1; i < 82; i++)
            if (second < 0 && obs_busy[i] === 1'b1 && obs_busy[i-1] === 1'b0) second = i;
        tests++;
        if (second !== 41) begin
            fails++;
            $display("FAIL b2b_period got=%0d exp=41", second);
        end
    endtask

    task automatic test_ignored();
        logic [2:0] e;
        push_frame(8'hA5, 4);
        push_idle(4);
        start_a(8'hA5);
        capture(0, 0, 10);
        ifa.tx_data  = 8'h3C;
        ifa.tx_valid = 1'b1;
        capture(0, 10, 2);
        ifa.tx_valid = 1'b0;
        capture(0, 12, 32);
        for (int i = 0; i < 44; i++) begin
            e = exp_q.pop_front();
            tests++;
            if ({obs_tx[i], obs_busy[i], obs_rdy[i]} !== e) begin
                fails++;
                $display("FAIL ignored cyc=%0d got=%b exp=%b", i,
                         {obs_tx[i], obs_busy[i], obs_rdy[i]}, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] e;
        push_frame(8'hA5, 4);
        start_a(8'hA5);
        capture(0, 0, 17);
        for (int i = 0; i < 17; i++) begin
            e = exp_q.pop_front();
            tests++;
            if ({obs_tx[i], obs_busy[i], obs_rdy[i]} !== e) begin
                fails++;
                $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", i,
                         {obs_tx[i], obs_busy[i], obs_rdy[i]}, e);
            end
        end
        exp_q.delete();
        // mid-cycle, well away from any rising edge
        reset = 1'b0;
        #1;
        tests++;
        if ({tx_a, busy_a, ifa.tx_ready} !== 3'b101) begin
            fails++;
            $display("FAIL midrst_async got=%b exp=101", {tx_a, busy_a, ifa.tx_ready});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        push_frame(8'h81, 4);
        push_idle(1);
        start_a(8'h81);
        capture(0, 0, 41);
        for (int i = 0; i < 41; i++) begin
            e = exp_q.pop_front();
            tests++;
            if ({obs_tx[i], obs_busy[i], obs_rdy[i]} !== e) begin
                fails++;
                $display("FAIL midrst_post cyc=%0d got=%b exp=%b", i,
                         {obs_tx[i], obs_busy[i], obs_rdy[i]}, e);
            end
        end
    endtask

    task automatic test_cpb1();
        logic [2:0] e;
        push_frame(8'h5A, 1);
        push_idle(1);
        @(posedge clk); #1;
        ifb.tx_valid = 1'b1;
        ifb.tx_data  = 8'h5A;
        @(posedge clk); #1;
        ifb.tx_valid = 1'b0;
        capture(1, 0, 11);
        for (int i = 0; i < 11; i++) begin
            e = exp_q.pop_front();
            tests++;
            if ({obs_tx[i], obs_busy[i], obs_rdy[i]} !== e) begin
                fails++;
                $display("FAIL cpb1 cyc=%0d got=%b exp=%b", i,
                         {obs_tx[i], obs_busy[i], obs_rdy[i]}, e);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ifa.tx_valid = 1'b0; ifa.tx_data = '0;
        ifb.tx_valid = 1'b0; ifb.tx_data = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored();
        test_mid_reset();
        test_cpb1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that is the sending end of the team's single-wire serial link. It accepts a parallel byte through a valid/ready handshake and shifts it out LSB-first on one output line, framed by a start bit (0) and a stop bit (1). Each bit is held for a programmable number of clock cycles. It sits between a parallel producer, such as a register or FIFO, and the board-level serial pin.

## Interface
Parameters:
- DATA_BITS, 8, number of payload bits per frame (legal range 5..9).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (legal ≥1).

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) forces the reset state immediately; deassertion is released on clk.
- tx_valid  input  1  producer has a byte on tx_data.
- tx_data  input  DATA_BITS  payload. Sampled only on the accepting edge.
- tx_ready  output  1  block can accept a frame. High only in IDLE.
- tx  output  1  serial line. Idle level is 1; driven from a register.
- busy  output  1  a frame is in progress (START, DATA or STOP).

## Operation
- States:
  - IDLE: tx=1, tx_ready=1, busy=0.
  - START: tx=0.
  - DATA: tx = shift_reg[0].
  - STOP: tx=1.
- Internal registers:
  - bit-timer, 0..CLKS_PER_BIT-1.
  - bit index, 0..DATA_BITS-1.
  - shift register, DATA_BITS wide.
- IDLE→START on a rising edge with tx_valid=1 and tx_ready=1. On that edge: shift_reg←tx_data, bit-timer←0.
- Within START, DATA and STOP, the bit-timer increments every cycle. At CLKS_PER_BIT-1 it wraps to 0 and the bit ends.
- START→DATA at the end of the start bit; bit index←0.
- In DATA, at each bit end: shift_reg shifts right by one and bit index increments. After bit index DATA_BITS-1 ends, DATA→STOP.
- STOP→IDLE at the end of the stop bit.
- tx_valid is ignored whenever tx_ready=0; no queuing. tx_data changes after acceptance do not affect the frame in flight.
- tx_ready is a combinational decode of state==IDLE. tx and busy are registered.
- With CLKS_PER_BIT=1 every bit lasts exactly one cycle. The bit-timer is effectively constant 0.

## Timing
- Reset values (reset=0): state=IDLE, tx=1, tx_ready=1, busy=0, bit-timer=0, bit index=0, shift_reg=0.
- Reset mid-frame: the frame is abandoned, and tx returns to 1 asynchronously with no clock edge required. After reset is released, the next frame starts from IDLE.
- Handshake edge T (tx_valid=1 in IDLE):
  - From T+1: tx=0, busy=1, tx_ready=0.
  - Start bit occupies cycles T+1 .. T+CLKS_PER_BIT.
  - Data bit k occupies cycles T+1+(k+1)·CLKS_PER_BIT .. T+(k+2)·CLKS_PER_BIT.
  - Stop bit occupies the final CLKS_PER_BIT cycles.
- Frame length: exactly (DATA_BITS+2)·CLKS_PER_BIT cycles of busy=1.
- End of frame: the cycle after the last stop cycle has state=IDLE, tx_ready=1, busy=0, tx=1.
- Back-to-back frames: a producer holding tx_valid=1 is accepted on the first IDLE edge. Frames are therefore separated by exactly one idle cycle with tx=1, so frame period = (DATA_BITS+2)·CLKS_PER_BIT+1 cycles.
- Simultaneous reset assertion and handshake: reset wins and no frame starts.

## Test plan
- Reset check: hold reset=0 for 3 cycles with tx_valid=1 → tx=1, tx_ready=1 and busy=0 throughout. No frame starts after release until the first accepting edge.
- Single frame (DATA_BITS=8, CLKS_PER_BIT=4), tx_data=8'hA5:
  - tx bit sequence, each bit held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for exactly 40 cycles, then tx_ready=1.
- Back-to-back, tx_valid held high with 8'h00 then 8'hFF:
  - Frame 1: start bit, eight 0 data bits, stop bit.
  - Exactly 1 idle cycle with tx=1.
  - Frame 2: start bit, eight 1 data bits, stop bit.
  - Second acceptance occurs exactly 41 cycles after the first.
- Ignored input: change tx_data to 8'h3C and pulse tx_valid during DATA of an 8'hA5 frame → the serial output still carries A5. No second frame starts until tx_ready returns to 1.
- Mid-frame reset: assert reset=0 during data bit 3 → tx goes to 1 within the same cycle, with no clock edge needed, and busy=0. After release, a new frame with 8'h81 transmits correctly.
- CLKS_PER_BIT=1, tx_data=8'h5A → 10-cycle frame with tx bit sequence 0,0,1,0,1,1,0,1,0,1.
